// File: rtl/flm_alloc_pkg.sv
// Shared helpers for the free-list allocator and its round-robin picker.
// Widths are always derived from the instance's N; nothing here fixes a width.
// Only the default pool size and the ID-width helper live here.
package flm_alloc_pkg;

  // Default pool size when the parent does not override N.
  localparam int FLM_DEFAULT_N = 16;

  // ID width for an n-entry pool; guards n < 2 so a bad N still elaborates far
  // enough for the static check in the top to report it.
  function automatic int flm_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flm_alloc_rr.sv
// Round-robin picker: first set bit of i_mask at or after i_ptr, wrapping mod N.
// Purely combinational, zero latency.
// No handshake; o_vld is low when the mask is empty.
module rr_pick
  import flm_alloc_pkg::*;
#(
  parameter int N = FLM_DEFAULT_N
) (
  input  logic [N-1:0]           i_mask,
  input  logic [flm_id_w(N)-1:0] i_ptr,
  output logic                   o_vld,
  output logic [flm_id_w(N)-1:0] o_id
);

  localparam int W = flm_id_w(N);
  localparam logic [W:0] NV = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_enc;
  logic [W:0]     w_sum;

  // Rotate so i_ptr lands at bit 0, priority-encode the lowest set bit, then
  // add the pointer back and wrap mod N (N need not be a power of two).
  always_comb begin
    w_dbl = {i_mask, i_mask} >> i_ptr;
    w_rot = w_dbl[N-1:0];
    w_enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = W'(i);
    end
    o_vld = |w_rot;
    w_sum = {1'b0, w_enc} + {1'b0, i_ptr};
    if (w_sum >= NV) w_sum = w_sum - NV;
    o_id = w_sum[W-1:0];
  end

endmodule

// File: rtl/flm_alloc.sv
// Free-list allocator: picks free IDs round-robin and offers them on a registered valid/ready port.
// Latency: first offer one edge after reset release; back-to-back transfers every cycle while IDs remain.
// Backpressure: offer holds stable while alloc_rdy is low; frees are always accepted.
module flm_alloc
  import flm_alloc_pkg::*;
#(
  parameter int N = FLM_DEFAULT_N
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   alloc_vld_r,
  output logic [flm_id_w(N)-1:0] alloc_id_r,
  input  logic                   alloc_rdy,
  input  logic                   free_vld,
  input  logic [flm_id_w(N)-1:0] free_id,
  input  logic                   clear,
  output logic [flm_id_w(N):0]   free_cnt_r,
  output logic                   idle_r,
  output logic                   exhausted_r
);

  localparam int W  = flm_id_w(N);
  localparam int CW = W + 1;

  typedef logic [W-1:0]  id_t;
  typedef logic [CW-1:0] cnt_t;

  generate
    if (N < 2) begin : g_bad_n
      $error("flm_alloc: N must be at least 2");
    end
  endgenerate

  // 1 = ID reserved (on offer) or issued to the consumer.
  logic [N-1:0] r_state;
  id_t          r_ptr;
  logic         r_alloc_vld;
  id_t          r_alloc_id;
  cnt_t         r_free_cnt;
  logic         r_idle;
  logic         r_exhausted;

  logic         w_xfer;
  logic         w_load;
  logic         w_pick_vld;
  id_t          w_pick_id;
  logic [N-1:0] w_load_oh;
  logic [N-1:0] w_free_oh;
  logic [N-1:0] w_state_nxt;
  cnt_t         w_cnt_nxt;
  logic         w_vld_nxt;
  id_t          w_id_nxt;
  id_t          w_ptr_nxt;
  logic         w_idle_nxt;
  logic         w_exh_nxt;

  // The picker sees registered state only, so an ID freed this cycle is not
  // pickable until the following cycle.
  rr_pick #(.N(N)) u_pick (
    .i_mask (~r_state),
    .i_ptr  (r_ptr),
    .o_vld  (w_pick_vld),
    .o_id   (w_pick_id)
  );

  // Next-state: reload the offer register when it is empty or being taken,
  // update the per-ID bits and the free counter.
  always_comb begin
    w_xfer      = r_alloc_vld & alloc_rdy;
    w_load      = (~r_alloc_vld | w_xfer) & w_pick_vld;
    w_load_oh   = w_load   ? ({{(N-1){1'b0}}, 1'b1} << w_pick_id) : '0;
    w_free_oh   = free_vld ? ({{(N-1){1'b0}}, 1'b1} << free_id)   : '0;
    w_state_nxt = (r_state | w_load_oh) & ~w_free_oh;

    w_cnt_nxt = r_free_cnt;
    if (w_load && !free_vld)      w_cnt_nxt = r_free_cnt - cnt_t'(1);
    else if (!w_load && free_vld) w_cnt_nxt = r_free_cnt + cnt_t'(1);

    w_vld_nxt = r_alloc_vld;
    w_id_nxt  = r_alloc_id;
    w_ptr_nxt = r_ptr;
    if (w_load) begin
      w_vld_nxt = 1'b1;
      w_id_nxt  = w_pick_id;
      w_ptr_nxt = (w_pick_id == id_t'(N - 1)) ? '0 : w_pick_id + id_t'(1);
    end else if (w_xfer) begin
      w_vld_nxt = 1'b0;
    end

    // Idle means every ID is either free or sitting in the offer register.
    w_idle_nxt = (w_cnt_nxt + cnt_t'(w_vld_nxt)) == cnt_t'(N);
    w_exh_nxt  = (w_cnt_nxt == '0);
  end

  // State registers; clear restores reset values and overrides any load,
  // transfer or free in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= '0;
      r_ptr       <= '0;
      r_alloc_vld <= 1'b0;
      r_alloc_id  <= '0;
      r_free_cnt  <= cnt_t'(N);
      r_idle      <= 1'b1;
      r_exhausted <= 1'b0;
    end else if (clear) begin
      r_state     <= '0;
      r_ptr       <= '0;
      r_alloc_vld <= 1'b0;
      r_alloc_id  <= '0;
      r_free_cnt  <= cnt_t'(N);
      r_idle      <= 1'b1;
      r_exhausted <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_alloc_vld <= w_vld_nxt;
      r_alloc_id  <= w_id_nxt;
      r_free_cnt  <= w_cnt_nxt;
      r_idle      <= w_idle_nxt;
      r_exhausted <= w_exh_nxt;
    end
  end

  assign alloc_vld_r = r_alloc_vld;
  assign alloc_id_r  = r_alloc_id;
  assign free_cnt_r  = r_free_cnt;
  assign idle_r      = r_idle;
  assign exhausted_r = r_exhausted;

  // Returning an ID that is not out with the consumer is a protocol error.
  a_free_unissued: assert property (@(posedge clk) disable iff (rst)
    (free_vld && !clear) |-> r_state[free_id]);

  // The ID sitting in the offer register has not been handed out yet.
  a_free_on_offer: assert property (@(posedge clk) disable iff (rst)
    (free_vld && !clear) |-> !(r_alloc_vld && (free_id == r_alloc_id)));

endmodule
